bj_redirect_ctrl: RTL and testbench
===================================

Name: bj_redirect_ctrl

Overview:
- Sequences the control-flow redirect that follows branch/jump resolution in the EX stage.
- Consumes the taken decision (PC_SEL) and the target address from the branch detect/ALU path.
- Waits for the instruction memory to accept a new fetch address, drives the PC redirect, and flushes wrong-path instructions from the IF/ID and ID/EX pipeline registers.
- Keeps saturating branch statistics for the perf/debug path.

Parameters:
- ADDR_W, 32, width of PC/target address
- FLUSH_CYCLES, 2, total cycles FLUSH_IF_ID is asserted per redirect (legal range 1..7)
- CNT_W, 16, width of each statistics counter

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- BJ_VALID  input  1  a branch/jump instruction occupies EX this cycle
- PC_SEL  input  1  branch/jump taken (from branch detect); meaningful only when BJ_VALID=1
- STALL_EX  input  1  EX stage frozen; the resolution is not final
- TARGET_ADDR  input  ADDR_W  computed branch/jump target
- IMEM_BUSY  input  1  instruction memory cannot accept a new fetch address
- PC_REDIRECT  output  1  one-cycle pulse: load PC from PC_TARGET_OUT
- PC_TARGET_OUT  output  ADDR_W  latched target with bits [1:0] forced to 0
- FLUSH_IF_ID  output  1  bubble the IF/ID register
- FLUSH_ID_EX  output  1  bubble the ID/EX register
- BJ_STALL  output  1  freeze PC and IF/ID while a redirect waits on IMEM
- MISALIGN  output  1  one-cycle pulse: accepted taken target had [1:0] != 0
- TAKEN_COUNT  output  CNT_W  number of accepted taken branches/jumps
- RESOLVED_COUNT  output  CNT_W  number of accepted branch/jump resolutions

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; all outputs 0; both counters 0; latched target 0. Asserting RESET in any state aborts the redirect in progress with no further pulses.
- Accept condition: state==IDLE && BJ_VALID && !STALL_EX.
  - Every accept increments RESOLVED_COUNT.
  - An accept with PC_SEL=1 also increments TAKEN_COUNT.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- BJ_VALID outside IDLE is ignored and not counted. Such instructions are wrong-path and are being flushed.
- All outputs are registered. Redirect latency is 1 cycle from accept when IMEM is free.
- FSM states: IDLE, WAIT_IMEM, REDIRECT, DRAIN.
- IDLE:
  - Accept with PC_SEL=1: latch {TARGET_ADDR[ADDR_W-1:2],2'b00}. Pulse MISALIGN next cycle if TARGET_ADDR[1:0]!=0.
  - Next state is WAIT_IMEM if IMEM_BUSY=1 in the accept cycle, otherwise REDIRECT.
  - Accept with PC_SEL=0: stay IDLE; only the counter updates.
- WAIT_IMEM:
  - BJ_STALL=1 and FLUSH_ID_EX=1 in every cycle, so no new instruction enters EX.
  - Leave to REDIRECT in the cycle after IMEM_BUSY is sampled 0. No time-out.
- REDIRECT (exactly 1 cycle): PC_REDIRECT=1, FLUSH_IF_ID=1, FLUSH_ID_EX=1, BJ_STALL=0.
  - Next state is DRAIN if FLUSH_CYCLES>1, else IDLE.
- DRAIN:
  - FLUSH_IF_ID=1 for FLUSH_CYCLES-1 cycles, counted by a down-counter loaded on REDIRECT entry.
  - Return to IDLE when the counter reaches 0.
  - IMEM_BUSY is ignored in this state.
- PC_TARGET_OUT holds the latched value from accept until the next accept; it is stable whenever PC_REDIRECT=1.
- STALL_EX=1 with BJ_VALID=1 in IDLE: no action and no count. Re-evaluate each cycle until STALL_EX=0.
- Back-to-back taken branches: the second is accepted only once the FSM is back in IDLE. The earliest acceptance is the cycle after DRAIN ends.
- Simultaneous accept and IMEM_BUSY rising: IMEM_BUSY as sampled in the accept cycle decides WAIT_IMEM vs REDIRECT.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - state enum IDLE/WAIT_IMEM/REDIRECT/DRAIN, 2-bit encoding
  - constant for the PC alignment mask
  - default CNT_W
- Sub-module: sat_counter (parameter W; inputs CLK, RESET, INC; output COUNT). Instantiated twice for the statistics counters.

Test Plan:
- Taken branch, IMEM free: BJ_VALID=1, PC_SEL=1, TARGET_ADDR=0x0000_0100 at cycle N -> at N+1: PC_REDIRECT=1, PC_TARGET_OUT=0x100, FLUSH_IF_ID=FLUSH_ID_EX=1. At N+2: FLUSH_IF_ID only. At N+3: IDLE. TAKEN_COUNT=1, RESOLVED_COUNT=1.
- Not-taken branch: BJ_VALID=1, PC_SEL=0 -> no redirect or flush; RESOLVED_COUNT=1, TAKEN_COUNT=0.
- IMEM busy for 3 cycles from accept: BJ_STALL=1 and FLUSH_ID_EX=1 for 3 cycles; PC_REDIRECT pulses once, in the cycle after IMEM_BUSY falls; PC_TARGET_OUT unchanged throughout.
- STALL_EX=1 for 2 cycles with a taken branch in EX -> no counting or redirect during the stall; a single redirect follows STALL_EX falling; counters advance by exactly 1.
- Misaligned target 0x0000_0203 -> MISALIGN pulse; PC_TARGET_OUT=0x0000_0200. A BJ_VALID during DRAIN is ignored and not counted.
- RESET asserted in WAIT_IMEM -> next cycle all outputs 0 and counters 0; no PC_REDIRECT after IMEM_BUSY falls. Saturation check with CNT_W=2: 5 taken branches -> TAKEN_COUNT=3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the branch/jump redirect control path.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IMEM = 2'd1,
    REDIRECT  = 2'd2,
    DRAIN     = 2'd3
  } bj_state_e;

  // Low PC bits that must be zero for a legal fetch address
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

  localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] COUNT
);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (INC && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/bj_redirect_ctrl.sv
// Sequences PC redirect and pipeline flush after branch/jump resolution in EX,
// and keeps saturating taken/resolved statistics.
module bj_redirect_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BJ_VALID,
  input  logic              PC_SEL,
  input  logic              STALL_EX,
  input  logic [ADDR_W-1:0] TARGET_ADDR,
  input  logic              IMEM_BUSY,
  output logic              PC_REDIRECT,
  output logic [ADDR_W-1:0] PC_TARGET_OUT,
  output logic              FLUSH_IF_ID,
  output logic              FLUSH_ID_EX,
  output logic              BJ_STALL,
  output logic              MISALIGN,
  output logic [CNT_W-1:0]  TAKEN_COUNT,
  output logic [CNT_W-1:0]  RESOLVED_COUNT
);

  localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_CYCLES - 1);

  bj_state_e         state_q, state_d;
  logic [2:0]        drain_q, drain_d;
  logic [ADDR_W-1:0] target_q;
  logic              redirect_q, flush_if_id_q, flush_id_ex_q, stall_q, misalign_q;
  logic              accept, take;

  assign accept = (state_q == IDLE) && BJ_VALID && !STALL_EX;
  assign take   = accept && PC_SEL;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE:      if (take) state_d = IMEM_BUSY ? WAIT_IMEM : REDIRECT;
      WAIT_IMEM: if (!IMEM_BUSY) state_d = REDIRECT;
      REDIRECT:  state_d = (FLUSH_CYCLES > 1) ? DRAIN : IDLE;
      DRAIN: begin
        drain_d = drain_q - 3'd1;
        if (drain_q <= 3'd1) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
    // Drain length is armed whenever a redirect is about to issue
    if (state_d == REDIRECT) drain_d = DRAIN_LOAD;
  end

  // Outputs are registered as a decode of the state being entered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      drain_q       <= '0;
      target_q      <= '0;
      redirect_q    <= 1'b0;
      flush_if_id_q <= 1'b0;
      flush_id_ex_q <= 1'b0;
      stall_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      redirect_q    <= (state_d == REDIRECT);
      flush_if_id_q <= (state_d == REDIRECT) || (state_d == DRAIN);
      flush_id_ex_q <= (state_d == REDIRECT) || (state_d == WAIT_IMEM);
      stall_q       <= (state_d == WAIT_IMEM);
      misalign_q    <= take && ((TARGET_ADDR[1:0] & PC_ALIGN_MASK) != 2'b00);
      if (take) begin
        target_q <= {TARGET_ADDR[ADDR_W-1:2], TARGET_ADDR[1:0] & ~PC_ALIGN_MASK};
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (take),
    .COUNT (TAKEN_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_resolved_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (accept),
    .COUNT (RESOLVED_COUNT)
  );

  assign PC_REDIRECT   = redirect_q;
  assign PC_TARGET_OUT = target_q;
  assign FLUSH_IF_ID   = flush_if_id_q;
  assign FLUSH_ID_EX   = flush_id_ex_q;
  assign BJ_STALL      = stall_q;
  assign MISALIGN      = misalign_q;

endmodule

// File: tb/tb_bj_redirect_ctrl.sv
// Directed bench for bj_redirect_ctrl: a default instance plus a 2-bit-counter
// instance sharing the same stimulus for the saturation case.
module tb_bj_redirect_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, BJ_VALID, PC_SEL, STALL_EX, IMEM_BUSY;
  logic [31:0] TARGET_ADDR;

  logic        redir, fif, fidex, stall, mis;
  logic [31:0] tgt;
  logic [15:0] taken, resolved;

  logic        redir_s, fif_s, fidex_s, stall_s, mis_s;
  logic [31:0] tgt_s;
  logic [1:0]  taken_s, resolved_s;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  bj_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .BJ_VALID(BJ_VALID), .PC_SEL(PC_SEL),
    .STALL_EX(STALL_EX), .TARGET_ADDR(TARGET_ADDR), .IMEM_BUSY(IMEM_BUSY),
    .PC_REDIRECT(redir), .PC_TARGET_OUT(tgt), .FLUSH_IF_ID(fif),
    .FLUSH_ID_EX(fidex), .BJ_STALL(stall), .MISALIGN(mis),
    .TAKEN_COUNT(taken), .RESOLVED_COUNT(resolved)
  );

  bj_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut_s (
    .CLK(CLK), .RESET(RESET), .BJ_VALID(BJ_VALID), .PC_SEL(PC_SEL),
    .STALL_EX(STALL_EX), .TARGET_ADDR(TARGET_ADDR), .IMEM_BUSY(IMEM_BUSY),
    .PC_REDIRECT(redir_s), .PC_TARGET_OUT(tgt_s), .FLUSH_IF_ID(fif_s),
    .FLUSH_ID_EX(fidex_s), .BJ_STALL(stall_s), .MISALIGN(mis_s),
    .TAKEN_COUNT(taken_s), .RESOLVED_COUNT(resolved_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic e_redir, input logic e_fif,
                           input logic e_fidex, input logic e_stall);
    check({tag, ".redirect"}, 32'(redir), 32'(e_redir));
    check({tag, ".flush_if_id"}, 32'(fif), 32'(e_fif));
    check({tag, ".flush_id_ex"}, 32'(fidex), 32'(e_fidex));
    check({tag, ".bj_stall"}, 32'(stall), 32'(e_stall));
  endtask

  task automatic check_cnt(input string tag, input int unsigned e_taken, input int unsigned e_res);
    check({tag, ".taken"}, 32'(taken), e_taken);
    check({tag, ".resolved"}, 32'(resolved), e_res);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic taken_i, input logic [31:0] addr);
    BJ_VALID    = 1'b1;
    PC_SEL      = taken_i;
    TARGET_ADDR = addr;
  endtask

  initial begin
    RESET = 1'b1; BJ_VALID = 1'b0; PC_SEL = 1'b0; STALL_EX = 1'b0;
    IMEM_BUSY = 1'b0; TARGET_ADDR = '0;
    tick(); tick();
    RESET = 1'b0;
    check_ctl("reset", 0, 0, 0, 0);
    check("reset.target", tgt, 32'h0);
    check("reset.misalign", 32'(mis), 0);
    check_cnt("reset", 0, 0);

    // Taken branch, IMEM free
    issue(1'b1, 32'h0000_0100);
    tick(); BJ_VALID = 1'b0;
    check_ctl("taken.n1", 1, 1, 1, 0);
    check("taken.n1.target", tgt, 32'h0000_0100);
    check_cnt("taken.n1", 1, 1);
    tick();
    check_ctl("taken.n2", 0, 1, 0, 0);
    tick();
    check_ctl("taken.n3", 0, 0, 0, 0);

    // Not-taken branch
    issue(1'b0, 32'h0000_0FF0);
    tick(); BJ_VALID = 1'b0;
    check_ctl("ntaken.n1", 0, 0, 0, 0);
    check_cnt("ntaken", 1, 2);
    tick();
    check_ctl("ntaken.n2", 0, 0, 0, 0);

    // IMEM busy during accept and the following two cycles
    issue(1'b1, 32'h0000_2000);
    IMEM_BUSY = 1'b1;
    tick(); BJ_VALID = 1'b0;
    check_ctl("busy.n1", 0, 0, 1, 1);
    check("busy.n1.target", tgt, 32'h0000_2000);
    tick();
    check_ctl("busy.n2", 0, 0, 1, 1);
    tick(); IMEM_BUSY = 1'b0;
    check_ctl("busy.n3", 0, 0, 1, 1);
    tick();
    check_ctl("busy.n4", 1, 1, 1, 0);
    check("busy.n4.target", tgt, 32'h0000_2000);
    check_cnt("busy", 2, 3);
    tick();
    check_ctl("busy.n5", 0, 1, 0, 0);
    tick();
    check_ctl("busy.n6", 0, 0, 0, 0);

    // STALL_EX holds off the resolution
    issue(1'b1, 32'h0000_0300);
    STALL_EX = 1'b1;
    tick();
    check_ctl("stallex.n1", 0, 0, 0, 0);
    check_cnt("stallex.n1", 2, 3);
    tick();
    check_ctl("stallex.n2", 0, 0, 0, 0);
    check_cnt("stallex.n2", 2, 3);
    STALL_EX = 1'b0;
    tick(); BJ_VALID = 1'b0;
    check_ctl("stallex.n3", 1, 1, 1, 0);
    check("stallex.target", tgt, 32'h0000_0300);
    check_cnt("stallex.n3", 3, 4);
    tick(); tick();

    // Misaligned target, BJ_VALID during REDIRECT/DRAIN ignored, back-to-back accept
    issue(1'b1, 32'h0000_0203);
    tick();
    check("mis.pulse", 32'(mis), 1);
    check("mis.target", tgt, 32'h0000_0200);
    check_ctl("mis.r", 1, 1, 1, 0);
    issue(1'b1, 32'h0000_0400);
    tick();
    check("mis.pulse_end", 32'(mis), 0);
    check_ctl("mis.drain", 0, 1, 0, 0);
    tick();
    check_ctl("mis.idle", 0, 0, 0, 0);
    check("mis.target_held", tgt, 32'h0000_0200);
    check_cnt("mis.idle", 4, 5);
    tick(); BJ_VALID = 1'b0;
    check_ctl("b2b.r", 1, 1, 1, 0);
    check("b2b.target", tgt, 32'h0000_0400);
    check("b2b.misalign", 32'(mis), 0);
    check_cnt("b2b", 5, 6);
    tick(); tick();

    // Reset while waiting on IMEM
    issue(1'b1, 32'h0000_0500);
    IMEM_BUSY = 1'b1;
    tick(); BJ_VALID = 1'b0;
    check_ctl("rstwait.pre", 0, 0, 1, 1);
    RESET = 1'b1;
    tick(); RESET = 1'b0;
    check_ctl("rstwait.post", 0, 0, 0, 0);
    check("rstwait.target", tgt, 32'h0);
    check("rstwait.misalign", 32'(mis), 0);
    check_cnt("rstwait", 0, 0);
    check("rstwait.small_taken", 32'(taken_s), 0);
    IMEM_BUSY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstwait.no_redirect", 32'(redir), 0);
    end

    // Saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 32'h0000_1000 + 32'(i) * 32'h10);
      tick(); BJ_VALID = 1'b0;
      tick(); tick();
    end
    check("sat.small_taken", 32'(taken_s), 3);
    check("sat.small_resolved", 32'(resolved_s), 3);
    check_cnt("sat.wide", 5, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
